// File: rtl/share_bank_access_sched.sv
// Serialises one latched batch of shared-bank requests onto the single bank port,
// lowest requestor index first, and pulses batch_done_o once the batch has drained.
module share_bank_access_sched #(
  parameter int SHARED_BANK_NUM    = 5,
  parameter int RQST_ADDR_BITWIDTH = 2,
  parameter int RQST_IDX_WIDTH     = 3,
  parameter int CNT_WIDTH          = 3
) (
  input  logic                                         sys_clk,
  input  logic                                         rstn,
  input  logic [SHARED_BANK_NUM-1:0]                   share_rqstFlag_i,
  input  logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] rqst_addr_i,
  input  logic                                         rqst_valid_i,
  output logic                                         rqst_ready_o,
  output logic                                         bank_en_o,
  output logic [RQST_ADDR_BITWIDTH-1:0]                bank_addr_o,
  output logic [RQST_IDX_WIDTH-1:0]                    bank_rqstIdx_o,
  input  logic                                         bank_ready_i,
  output logic [SHARED_BANK_NUM-1:0]                   grant_o,
  output logic [CNT_WIDTH-1:0]                         batch_cnt_o,
  output logic                                         batch_done_o
);

  localparam int BUF_W = RQST_ADDR_BITWIDTH * SHARED_BANK_NUM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [SHARED_BANK_NUM-1:0] f);
    logic [CNT_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < SHARED_BANK_NUM; i++) begin
      acc = acc + CNT_WIDTH'(f[i]);
    end
    return acc;
  endfunction

  // Scanning downward lets the lowest set index overwrite any higher one.
  function automatic logic [RQST_IDX_WIDTH-1:0] lowest_idx(input logic [SHARED_BANK_NUM-1:0] p);
    logic [RQST_IDX_WIDTH-1:0] res;
    res = '0;
    for (int i = SHARED_BANK_NUM - 1; i >= 0; i--) begin
      if (p[i]) begin
        res = RQST_IDX_WIDTH'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [SHARED_BANK_NUM-1:0] onehot(input logic [RQST_IDX_WIDTH-1:0] idx);
    logic [SHARED_BANK_NUM-1:0] res;
    res = '0;
    for (int i = 0; i < SHARED_BANK_NUM; i++) begin
      res[i] = (idx == RQST_IDX_WIDTH'(i));
    end
    return res;
  endfunction

  function automatic logic [RQST_ADDR_BITWIDTH-1:0] addr_of(input logic [BUF_W-1:0] buf_v,
                                                           input logic [RQST_IDX_WIDTH-1:0] idx);
    logic [RQST_ADDR_BITWIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < SHARED_BANK_NUM; i++) begin
      if (idx == RQST_IDX_WIDTH'(i)) begin
        res = buf_v[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_e                        state_q, state_d;
  logic [SHARED_BANK_NUM-1:0]    pending_q, pending_d;
  logic [BUF_W-1:0]              addr_buf_q, addr_buf_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;

  logic                          ready_q, ready_d;
  logic                          en_q, en_d;
  logic [RQST_ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [RQST_IDX_WIDTH-1:0]     idx_q, idx_d;
  logic [SHARED_BANK_NUM-1:0]    grant_q, grant_d;
  logic                          done_q, done_d;
  logic [RQST_IDX_WIDTH-1:0]     sel_cur_s, sel_nxt_s;

  // Next-state logic; outputs are precomputed from the next state so they leave flops.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_buf_d = addr_buf_q;
    cnt_d      = cnt_q;
    sel_cur_s  = lowest_idx(pending_q);

    case (state_q)
      ST_IDLE: begin
        if (rqst_valid_i) begin
          pending_d  = share_rqstFlag_i;
          addr_buf_d = rqst_addr_i;
          cnt_d      = popcount(share_rqstFlag_i);
          if (share_rqstFlag_i != '0) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bank_ready_i) begin
          pending_d = pending_q & ~onehot(sel_cur_s);
          if (pending_d == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sel_nxt_s = lowest_idx(pending_d);
    ready_d   = (state_d == ST_IDLE);
    done_d    = (state_d == ST_DONE);
    en_d      = (state_d == ST_ISSUE);
    if (en_d) begin
      idx_d   = sel_nxt_s;
      addr_d  = addr_of(addr_buf_d, sel_nxt_s);
      grant_d = onehot(sel_nxt_s);
    end else begin
      idx_d   = '0;
      addr_d  = '0;
      grant_d = '0;
    end
  end

  // State, batch storage and output registers.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      addr_buf_q <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      en_q       <= 1'b0;
      addr_q     <= '0;
      idx_q      <= '0;
      grant_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_buf_q <= addr_buf_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
    end
  end

  assign rqst_ready_o   = ready_q;
  assign bank_en_o      = en_q;
  assign bank_addr_o    = addr_q;
  assign bank_rqstIdx_o = idx_q;
  assign grant_o        = grant_q;
  assign batch_cnt_o    = cnt_q;
  assign batch_done_o   = done_q;

endmodule

// File: tb/tb_share_bank_access_sched.sv
// Randomized bench for share_bank_access_sched: a queue of pending requestor indices
// predicts each presented access, the completion pulse and the return to idle.
module tb_share_bank_access_sched;

  logic       sys_clk;
  logic       rstn;
  logic [4:0] share_rqstFlag_i;
  logic [9:0] rqst_addr_i;
  logic       rqst_valid_i;
  logic       rqst_ready_o;
  logic       bank_en_o;
  logic [1:0] bank_addr_o;
  logic [2:0] bank_rqstIdx_o;
  logic       bank_ready_i;
  logic [4:0] grant_o;
  logic [2:0] batch_cnt_o;
  logic       batch_done_o;

  int n_vec;
  int n_err;

  share_bank_access_sched dut (
    .sys_clk          (sys_clk),
    .rstn             (rstn),
    .share_rqstFlag_i (share_rqstFlag_i),
    .rqst_addr_i      (rqst_addr_i),
    .rqst_valid_i     (rqst_valid_i),
    .rqst_ready_o     (rqst_ready_o),
    .bank_en_o        (bank_en_o),
    .bank_addr_o      (bank_addr_o),
    .bank_rqstIdx_o   (bank_rqstIdx_o),
    .bank_ready_i     (bank_ready_i),
    .grant_o          (grant_o),
    .batch_cnt_o      (batch_cnt_o),
    .batch_done_o     (batch_done_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(rqst_ready_o), 32'd1);
    check_eq({tag, "_en"},    32'(bank_en_o),    32'd0);
    check_eq({tag, "_grant"}, 32'(grant_o),      32'd0);
    check_eq({tag, "_idx"},   32'(bank_rqstIdx_o), 32'd0);
    check_eq({tag, "_addr"},  32'(bank_addr_o),  32'd0);
    check_eq({tag, "_cnt"},   32'(batch_cnt_o),  32'd0);
    check_eq({tag, "_done"},  32'(batch_done_o), 32'd0);
  endtask

  // Called at a falling edge while idle; returns at the falling edge of the idle cycle after done.
  task automatic run_batch(input logic [4:0] flags, input logic [9:0] addr,
                           input logic [31:0] rdy_pat, input bit junk);
    int q[$];
    int n;
    int cyc;
    logic br;
    n = $countones(flags);
    for (int i = 0; i < 5; i++) begin
      if (flags[i]) q.push_back(i);
    end
    check_eq("accept_ready", 32'(rqst_ready_o), 32'd1);
    share_rqstFlag_i = flags;
    rqst_addr_i      = addr;
    rqst_valid_i     = 1'b1;
    bank_ready_i     = 1'b0;
    @(negedge sys_clk);
    cyc = 0;
    while (q.size() > 0 && cyc < 64) begin
      check_eq("issue_en",    32'(bank_en_o),      32'd1);
      check_eq("issue_idx",   32'(bank_rqstIdx_o), 32'(q[0]));
      check_eq("issue_addr",  32'(bank_addr_o),    32'((addr >> (2 * q[0])) & 10'h3));
      check_eq("issue_grant", 32'(grant_o),        32'd1 << q[0]);
      check_eq("issue_ready", 32'(rqst_ready_o),   32'd0);
      check_eq("issue_done",  32'(batch_done_o),   32'd0);
      check_eq("issue_cnt",   32'(batch_cnt_o),    32'(n));
      br = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
      bank_ready_i = br;
      if (junk) begin
        rqst_valid_i     = 1'b1;
        share_rqstFlag_i = 5'($urandom);
        rqst_addr_i      = 10'($urandom);
      end else begin
        rqst_valid_i = 1'b0;
      end
      @(negedge sys_clk);
      if (br) void'(q.pop_front());
      cyc++;
    end
    check_eq("issue_drained", 32'(q.size()), 32'd0);
    check_eq("done_pulse", 32'(batch_done_o), 32'd1);
    check_eq("done_en",    32'(bank_en_o),    32'd0);
    check_eq("done_grant", 32'(grant_o),      32'd0);
    check_eq("done_ready", 32'(rqst_ready_o), 32'd0);
    check_eq("done_cnt",   32'(batch_cnt_o),  32'(n));
    bank_ready_i = 1'($urandom);
    rqst_valid_i = junk;
    share_rqstFlag_i = 5'($urandom);
    @(negedge sys_clk);
    rqst_valid_i = 1'b0;
    check_eq("post_ready", 32'(rqst_ready_o), 32'd1);
    check_eq("post_done",  32'(batch_done_o), 32'd0);
    check_eq("post_en",    32'(bank_en_o),    32'd0);
    check_eq("post_cnt",   32'(batch_cnt_o),  32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0;
    share_rqstFlag_i = 5'd0;
    rqst_addr_i = 10'd0;
    rqst_valid_i = 1'b0;
    bank_ready_i = 1'b0;

    repeat (3) @(negedge sys_clk);
    check_reset_outputs("rst_held");
    rstn = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("rst_released");

    // Two-request batch, always ready, then with two stall cycles, then with ignored valid pulses.
    run_batch(5'b10100, {2'd3, 2'd0, 2'd1, 2'd0, 2'd0}, 32'hFFFF_FFFF, 1'b0);
    run_batch(5'b10100, {2'd3, 2'd0, 2'd1, 2'd0, 2'd0}, 32'hFFFF_FFFC, 1'b0);
    run_batch(5'b10100, {2'd3, 2'd0, 2'd1, 2'd0, 2'd0}, 32'hFFFF_FFFF, 1'b1);
    // Empty and full batches.
    run_batch(5'b00000, 10'h2A5, 32'hFFFF_FFFF, 1'b0);
    run_batch(5'b11111, {2'd2, 2'd1, 2'd3, 2'd0, 2'd1}, 32'hFFFF_FFFF, 1'b0);

    // Mid-batch reset on a full batch.
    share_rqstFlag_i = 5'b11111;
    rqst_addr_i      = 10'h3C6;
    rqst_valid_i     = 1'b1;
    bank_ready_i     = 1'b1;
    @(negedge sys_clk);
    rqst_valid_i = 1'b0;
    check_eq("mid_idx0", 32'(bank_rqstIdx_o), 32'd0);
    @(negedge sys_clk);
    check_eq("mid_idx1", 32'(bank_rqstIdx_o), 32'd1);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check_eq("mid_rst_no_done", 32'(batch_done_o), 32'd0);
    end
    rstn = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("mid_rst_release");
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check_eq("mid_rst_idle_done", 32'(batch_done_o), 32'd0);
    end
    run_batch(5'b01011, 10'h1B4, 32'hFFFF_FFFF, 1'b0);

    // Randomized batches with random back-pressure and ignored valid traffic.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] pat;
      pat = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
      run_batch(5'($urandom), 10'($urandom), pat, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge sys_clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/share_bank_access_sched.md
# share_bank_access_sched

Serialises one batch of shared-column-bank access requests onto the single port of a partially-parallelised (shared) column bank. It sits directly downstream of the access request generator. It latches the per-requestor request flags and column addresses as one batch, then issues one access per accepted cycle in fixed ascending-index priority. It signals batch completion so the layer scheduler can advance.

## Interface
- SHARED_BANK_NUM, 5, number of requestors in the share group (flag vector width)
- RQST_ADDR_BITWIDTH, 2, bit width of each requestor's column address
- RQST_IDX_WIDTH, 3, width of requestor index output; must satisfy 2^RQST_IDX_WIDTH ≥ SHARED_BANK_NUM
- CNT_WIDTH, 3, width of batch request count; must satisfy 2^CNT_WIDTH > SHARED_BANK_NUM
- sys_clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- share_rqstFlag_i  in  SHARED_BANK_NUM  request flags from the request generator; bit i = requestor i needs the shared bank
- rqst_addr_i  in  RQST_ADDR_BITWIDTH*SHARED_BANK_NUM  concatenated column addresses; requestor i at bits [i*W +: W]
- rqst_valid_i  in  1  flags/addresses valid this cycle
- rqst_ready_o  out  1  scheduler idle, batch accepted when rqst_valid_i & rqst_ready_o
- bank_en_o  out  1  access to shared bank presented this cycle
- bank_addr_o  out  RQST_ADDR_BITWIDTH  column address of the presented access
- bank_rqstIdx_o  out  RQST_IDX_WIDTH  requestor index of the presented access
- bank_ready_i  in  1  shared bank consumes the presented access this cycle
- grant_o  out  SHARED_BANK_NUM  one-hot of the presented requestor, 0 when bank_en_o low
- batch_cnt_o  out  CNT_WIDTH  popcount of the latched batch flags
- batch_done_o  out  1  one-cycle pulse when every request of the batch has been consumed

## Operation
- FSM states: IDLE, ISSUE, DONE. Reset state IDLE.
- IDLE:
  - rqst_ready_o=1.
  - On accept, latch share_rqstFlag_i into pending[], latch rqst_addr_i into the address buffer, and set batch_cnt_o = popcount(share_rqstFlag_i).
  - If flags ≠ 0, go to ISSUE; else go to DONE.
  - rqst_valid_i is ignored outside IDLE. The latched batch is unaffected by input changes after accept.
- ISSUE:
  - sel = lowest set index of pending.
  - bank_en_o=1, bank_rqstIdx_o=sel, bank_addr_o=buffer[sel], grant_o=1<<sel.
  - When bank_ready_i=1, clear pending[sel].
  - If that clear empties pending, go to DONE; otherwise stay in ISSUE.
  - When bank_ready_i=0, outputs are held stable with no change (stall).
- DONE: batch_done_o=1 for exactly one cycle, then go to IDLE.
- All outputs are Moore (functions of registered state only). No combinational path from any input to any output.
- When bank_en_o=0: bank_addr_o=0, bank_rqstIdx_o=0, grant_o=0.
- batch_cnt_o holds its value until the next accept. It is not decremented.
- Reset (rstn low, any time including mid-batch):
  - FSM returns to IDLE.
  - pending, address buffer and batch_cnt_o are cleared to 0.
  - Outputs: rqst_ready_o=1 (IDLE), all others 0.
  - The batch in flight is discarded and batch_done_o is not pulsed.

## Timing
- Accept at rising edge k.
- ISSUE begins in cycle k+1, with bank_en_o high in cycle k+1.
- With bank_ready_i held high and n set flags:
  - accesses are presented in cycles k+1 … k+n;
  - batch_done_o is high in cycle k+n+1;
  - rqst_ready_o is high again in cycle k+n+2.
- Each low cycle of bank_ready_i in ISSUE adds one cycle to that schedule.
- Zero-flag batch: batch_done_o is high in cycle k+1 and rqst_ready_o is high in cycle k+2.
- Back-to-back batches: minimum spacing between accepts is n+2 cycles.
- Maximum n = SHARED_BANK_NUM, which gives batch_cnt_o = SHARED_BANK_NUM without overflow.

## Test plan
- Reset/idle: hold rstn=0, then release with no valid -> rqst_ready_o=1; bank_en_o, grant_o, batch_cnt_o and batch_done_o all 0.
- Two-request batch:
  - Stimulus: flags 5'b10100, rqst_addr_i = {2'd3,2'd0,2'd1,2'd0,2'd0}, bank_ready_i=1, accept at k.
  - Expected at k+1: idx=2, addr=1, grant_o=5'b00100.
  - Expected at k+2: idx=4, addr=3, grant_o=5'b10000.
  - Expected: batch_done_o at k+3, batch_cnt_o=2.
- Stall:
  - Stimulus: same batch, bank_ready_i=0 in cycles k+1 and k+2.
  - Expected: idx=2/addr=1 held for 3 cycles, then idx 4.
  - Expected: batch_done_o at k+5.
- Empty and full batches:
  - Flags 5'b00000 -> no bank_en_o, batch_done_o at k+1, batch_cnt_o=0.
  - Flags 5'b11111 -> indices 0,1,2,3,4 in order, batch_cnt_o=5, batch_done_o at k+6.
- Ignored valid: pulse rqst_valid_i with new flags during ISSUE -> current batch order, addresses and done timing unchanged; the new flags are not latched.
- Mid-batch reset: assert rstn=0 at k+2 of a 5'b11111 batch -> outputs return immediately to reset values; no batch_done_o; after release, a new batch is accepted normally.
